// File: rtl/zbieracz_wejsc.sv
// Collects six 4-bit words into one registered block for the sorting network; optional short blocks via ZBIERACZ_DOPELNIENIE_EN.
// Latency: wy_wazne rises the cycle after the edge accepting the last word; one block per 7 cycles at best.
// Backpressure: we_gotowy is low while a full block waits for wy_przyjete; the upstream holds its word.
module zbieracz_wejsc #(
    parameter int SZEROKOSC = 4,
    parameter int LICZBA    = 6
) (
    input  logic                          zegar,
    input  logic                          reset_n,
    input  logic [SZEROKOSC-1:0]          we_dane,
    input  logic                          we_wazne,
    output logic                          we_gotowy,
    output logic [SZEROKOSC*LICZBA-1:0]   wy_dane,
    output logic                          wy_wazne,
    input  logic                          wy_przyjete
`ifdef ZBIERACZ_DOPELNIENIE_EN
    ,
    input  logic                          we_ostatni,
    output logic [2:0]                    wy_liczba
`endif
);

    localparam int LW = (LICZBA > 1) ? $clog2(LICZBA) : 1;

    typedef enum logic {
        ZBIERANIE = 1'b0,
        PELNY     = 1'b1
    } stan_t;

    stan_t                                r_stan;
    stan_t                                w_stan_nast;
    logic [LW-1:0]                        r_licznik;
    logic [LW-1:0]                        w_licznik_nast;
    logic [LICZBA-1:0][SZEROKOSC-1:0]     r_sloty;
    logic [LICZBA-1:0][SZEROKOSC-1:0]     w_sloty_nast;
    logic                                 w_koniec;
    logic                                 w_ostatni;

`ifdef ZBIERACZ_DOPELNIENIE_EN
    assign w_ostatni = we_ostatni;
`else
    assign w_ostatni = 1'b0;
`endif

    always_comb begin
        w_stan_nast    = r_stan;
        w_licznik_nast = r_licznik;
        w_sloty_nast   = r_sloty;
        w_koniec       = 1'b0;
        case (r_stan)
            ZBIERANIE: begin
                if (we_wazne) begin
                    w_koniec = (r_licznik == LW'(LICZBA - 1)) || w_ostatni;
                    // Padding slots get all-ones so they sort to the top outputs.
                    for (int i = 0; i < LICZBA; i++) begin
                        if (LW'(i) == r_licznik) begin
                            w_sloty_nast[i] = we_dane;
                        end else if (w_ostatni && (LW'(i) > r_licznik)) begin
                            w_sloty_nast[i] = '1;
                        end
                    end
                    if (w_koniec) begin
                        w_stan_nast    = PELNY;
                        w_licznik_nast = '0;
                    end else begin
                        w_licznik_nast = r_licznik + 1'b1;
                    end
                end
            end
            PELNY: begin
                if (wy_przyjete) begin
                    w_stan_nast = ZBIERANIE;
                end
            end
            default: w_stan_nast = ZBIERANIE;
        endcase
    end

    always_ff @(posedge zegar or negedge reset_n) begin
        if (!reset_n) begin
            r_stan    <= ZBIERANIE;
            r_licznik <= '0;
            r_sloty   <= '0;
        end else begin
            r_stan    <= w_stan_nast;
            r_licznik <= w_licznik_nast;
            r_sloty   <= w_sloty_nast;
        end
    end

`ifdef ZBIERACZ_DOPELNIENIE_EN
    logic [2:0] r_liczba;

    // The closing word sits in slot licznik, so the real word count is licznik+1.
    always_ff @(posedge zegar or negedge reset_n) begin
        if (!reset_n) begin
            r_liczba <= 3'd0;
        end else if (w_koniec) begin
            r_liczba <= 3'(r_licznik) + 3'd1;
        end
    end

    assign wy_liczba = r_liczba;
`endif

    assign we_gotowy = (r_stan == ZBIERANIE);
    assign wy_wazne  = (r_stan == PELNY);
    assign wy_dane   = r_sloty;

endmodule

// File: tb/tb_zbieracz_wejsc.sv
// Bench for zbieracz_wejsc: directed scenarios plus randomized traffic, checked by a queue-based
// reference model and an independent output monitor.
module tb_zbieracz_wejsc;

    localparam int W = 4;
    localparam int N = 6;

    logic           zegar = 1'b0;
    logic           reset_n = 1'b0;
    logic [W-1:0]   we_dane = '0;
    logic           we_wazne = 1'b0;
    logic           we_gotowy;
    logic [W*N-1:0] wy_dane;
    logic           wy_wazne;
    logic           wy_przyjete = 1'b0;
`ifdef ZBIERACZ_DOPELNIENIE_EN
    logic           we_ostatni = 1'b0;
    logic [2:0]     wy_liczba;
`endif

    zbieracz_wejsc #(.SZEROKOSC(W), .LICZBA(N)) dut (
        .zegar       (zegar),
        .reset_n     (reset_n),
        .we_dane     (we_dane),
        .we_wazne    (we_wazne),
        .we_gotowy   (we_gotowy),
        .wy_dane     (wy_dane),
        .wy_wazne    (wy_wazne),
        .wy_przyjete (wy_przyjete)
`ifdef ZBIERACZ_DOPELNIENIE_EN
        ,
        .we_ostatni  (we_ostatni),
        .wy_liczba   (wy_liczba)
`endif
    );

    always #5 zegar = ~zegar;

    typedef struct {
        logic [W*N-1:0] dane;
        int             liczba;
    } blok_t;

    blok_t oczek[$];
    int    czesc[$];
    int    rise_cykl[$];
    int    n_cmp = 0;
    int    n_err = 0;
    int    n_blk = 0;
    int    n_rises = 0;
    int    cykl = 0;
    bit    ack_en = 1'b0;
    bit    ack_rand = 1'b0;
    bit    ack_noise = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: words accumulate in a list; a full or closed list becomes an expected block.
    task automatic model_accept(input logic [W-1:0] d, input bit last);
        blok_t b;
        czesc.push_back(int'(d));
        if (czesc.size() == N || last) begin
            b.liczba = czesc.size();
            while (czesc.size() < N) czesc.push_back(15);
            b.dane = '0;
            for (int i = 0; i < N; i++) b.dane[W*i +: W] = W'(czesc[i]);
            oczek.push_back(b);
            czesc.delete();
            n_blk++;
        end
    endtask

    task automatic send_word(input logic [W-1:0] d, input bit last);
        int t;
        @(negedge zegar);
        we_dane  = d;
        we_wazne = 1'b1;
`ifdef ZBIERACZ_DOPELNIENIE_EN
        we_ostatni = last;
`endif
        t = 0;
        while (!we_gotowy && t < 200) begin
            @(negedge zegar);
            t++;
        end
        if (!we_gotowy) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: we_gotowy stuck at %0b, required 1", we_gotowy);
            we_wazne = 1'b0;
        end else begin
            @(posedge zegar);
            model_accept(d, last);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge zegar);
            we_wazne = 1'b0;
            we_dane  = W'($urandom);
`ifdef ZBIERACZ_DOPELNIENIE_EN
            we_ostatni = 1'($urandom);
`endif
        end
    endtask

    task automatic ack_one();
        idle(1);
        @(posedge zegar);
        ack_en = 1'b1;
        @(posedge zegar);
        #1;
        check("ack_wazne", 32'(wy_wazne), 32'd0);
        check("ack_gotowy", 32'(we_gotowy), 32'd1);
        ack_en = 1'b0;
    endtask

    // Consumer
    initial begin
        forever begin
            @(negedge zegar);
            if (wy_wazne)
                wy_przyjete = ack_en && (!ack_rand || ($urandom_range(0, 2) == 0));
            else
                wy_przyjete = ack_noise && ($urandom_range(0, 1) == 1);
        end
    end

    // Monitor
    initial begin
        bit             prev = 1'b0;
        int             last_blk = 0;
        logic [W*N-1:0] held = '0;
        blok_t          b;
        forever begin
            @(posedge zegar);
            #1;
            cykl++;
            check("gotowy_vs_wazne", 32'(we_gotowy), 32'(!wy_wazne));
            if (wy_wazne && !prev) begin
                n_rises++;
                rise_cykl.push_back(cykl);
                if (oczek.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_block: got %0h, expected no block", wy_dane);
                end else begin
                    b = oczek.pop_front();
                    check("blok_dane", 32'(wy_dane), 32'(b.dane));
`ifdef ZBIERACZ_DOPELNIENIE_EN
                    check("blok_liczba", 32'(wy_liczba), 32'(b.liczba));
`endif
                end
                held = wy_dane;
            end else if (wy_wazne && prev) begin
                check("blok_stabilny", 32'(wy_dane), 32'(held));
            end
            if ((wy_wazne && !prev) || (n_blk != last_blk))
                check("latencja", 32'(n_rises), 32'(n_blk));
            last_blk = n_blk;
            prev = wy_wazne;
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation still running at %0t, required finish", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "timeout");
    end

    initial begin
        int srt[N];
        int exp_srt[N];
        logic [3:0] d0;
        repeat (3) @(posedge zegar);
        #1;
        check("reset_dane", 32'(wy_dane), 32'd0);
        check("reset_wazne", 32'(wy_wazne), 32'd0);
        check("reset_gotowy", 32'(we_gotowy), 32'd1);
`ifdef ZBIERACZ_DOPELNIENIE_EN
        check("reset_liczba", 32'(wy_liczba), 32'd0);
`endif
        @(negedge zegar);
        reset_n = 1'b1;

        // Back-to-back block, then held with noise on the input
        send_word(4'h5, 0); send_word(4'h3, 0); send_word(4'h9, 0);
        send_word(4'h0, 0); send_word(4'hF, 0); send_word(4'h1, 0);
        #1;
        check("pelny_gotowy", 32'(we_gotowy), 32'd0);
        for (int i = 0; i < N; i++) srt[i] = int'(wy_dane[W*i +: W]);
        srt.sort();
        exp_srt = '{0, 1, 3, 5, 9, 15};
        for (int i = 0; i < N; i++) check("posortowane", 32'(srt[i]), 32'(exp_srt[i]));
        repeat (10) begin
            @(negedge zegar);
            we_wazne = 1'b1;
            we_dane  = 4'h7;
        end
        ack_one();

        // Gaps between words
        foreach (exp_srt[i]) exp_srt[i] = 0;
        for (int i = 0; i < N; i++) begin
            d0 = (i < 2) ? 4'h2 : (i < 4) ? 4'h8 : 4'h4;
            idle($urandom_range(0, 3));
            send_word(d0, 0);
        end
        ack_one();

        // Reset mid-block discards partial words
        send_word(4'hA, 0); send_word(4'hB, 0); send_word(4'hC, 0);
        @(negedge zegar);
        we_wazne = 1'b0;
        reset_n = 1'b0;
        czesc.delete();
        #1;
        check("rst_mid_dane", 32'(wy_dane), 32'd0);
        check("rst_mid_gotowy", 32'(we_gotowy), 32'd1);
        @(negedge zegar);
        reset_n = 1'b1;
        for (int i = 0; i < N; i++) send_word(W'(i + 1), 0);

        // Reset while full drops valid at once
        idle(2);
        @(negedge zegar);
        reset_n = 1'b0;
        #1;
        check("rst_pelny_wazne", 32'(wy_wazne), 32'd0);
        check("rst_pelny_dane", 32'(wy_dane), 32'd0);
        @(negedge zegar);
        reset_n = 1'b1;

`ifdef ZBIERACZ_DOPELNIENIE_EN
        send_word(4'h6, 0);
        send_word(4'h2, 1);
        ack_one();
`endif

        // Two blocks with acknowledge in the first full cycle
        ack_en = 1'b1;
        ack_rand = 1'b0;
        for (int i = 0; i < 2 * N; i++) send_word(W'($urandom), 0);
        idle(3);
        check("przepustowosc", 32'(rise_cykl[rise_cykl.size() - 1] - rise_cykl[rise_cykl.size() - 2]), 32'd7);

        // Randomized traffic
        ack_rand = 1'b1;
        ack_noise = 1'b1;
        for (int i = 0; i < 20 * N; i++) begin
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
`ifdef ZBIERACZ_DOPELNIENIE_EN
            send_word(W'($urandom), ($urandom_range(0, 4) == 0));
`else
            send_word(W'($urandom), 0);
`endif
        end
        idle(1);
        begin
            int t = 0;
            while (oczek.size() != 0 && t < 200) begin
                @(posedge zegar);
                t++;
            end
        end
        repeat (10) @(posedge zegar);
        check("drain_oczek", 32'(oczek.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/zbieracz_wejsc.md
# zbieracz_wejsc

Input collector feeding the 6-input, 4-bit sorting network. Accepts a stream of 4-bit words over a valid/ready handshake, assembles six consecutive words into a registered parallel block, and holds that block stable with a valid flag until the consumer acknowledges it. The sorting network is purely combinational, so this block provides its clocked, handshaked front end; slot i drives network input `wejscie_i`.

## Interface
- `SZEROKOSC`, 4, bits per word; must match the network's word width.
- `LICZBA`, 6, words per block; fixed at 6 for the current network, kept as a parameter for counter sizing.

- `zegar`  in  1  clock; all state changes on the rising edge.
- `reset_n`  in  1  reset; asynchronous, active-low.
- `we_dane`  in  SZEROKOSC  incoming word.
- `we_wazne`  in  1  `we_dane` is valid.
- `we_gotowy`  out  1  block can accept a word this cycle.
- `wy_dane`  out  SZEROKOSC*LICZBA  assembled block; slot i occupies bits [SZEROKOSC*i +: SZEROKOSC] and feeds `wejscie_i`.
- `wy_wazne`  out  1  `wy_dane` holds a complete block.
- `wy_przyjete`  in  1  consumer has taken the block.

## Operation
- Two states:
  - `ZBIERANIE` (collecting).
  - `PELNY` (full).
- Counter `licznik` runs 0..LICZBA-1 and gives the next slot index.
- `we_gotowy` = (state == `ZBIERANIE`). It is decoded from the state register, with no combinational path from `wy_przyjete`.
- Input transfer: `we_wazne && we_gotowy` at a rising edge.
  - `we_dane` is written into slot `licznik`, and `licznik` increments.
  - On the transfer with `licznik == LICZBA-1`: `licznik` returns to 0, the state moves to `PELNY`, and `wy_wazne` is set.
- In `PELNY`:
  - `wy_dane` and `wy_wazne` are frozen.
  - `we_wazne` is ignored; the upstream must hold its word.
- Output transfer: `wy_przyjete` high at a rising edge while in `PELNY`. The state returns to `ZBIERANIE` and `wy_wazne` clears.
- `wy_przyjete` in `ZBIERANIE` has no effect.
- Slots are not cleared between blocks. During `ZBIERANIE`, `wy_dane` contents are don't-care for the consumer.
- `we_wazne` low in `ZBIERANIE` means no change; gaps between words are allowed.

## Timing
- Reset (asynchronous assert, synchronous release):
  - state = `ZBIERANIE`, `licznik` = 0.
  - `wy_dane` = 0, `wy_wazne` = 0.
  - `we_gotowy` = 1.
- Latency: `wy_wazne` rises in the cycle after the edge that accepts the 6th word. Minimum is 6 cycles from the first accepted word with back-to-back input.
- `we_gotowy` falls together with the rise of `wy_wazne`. It returns to 1 in the cycle after the acknowledge edge.
- Throughput: one block per 7 cycles at best (6 fills + 1 acknowledge cycle).
- Reset mid-block discards the partial block. Reset while `PELNY` drops `wy_wazne` immediately (asynchronous).
- The sorted result is valid combinationally from `wy_dane` whenever `wy_wazne` = 1.

## Configuration
- Macro: `ZBIERACZ_DOPELNIENIE_EN`.
- When defined, two ports are added:
  - `we_ostatni`  in  1  marks the accepted word as the last of a short block.
  - `wy_liczba`  out  3  number of real words in the block; reset value 0.
- Behaviour with the macro defined:
  - A transfer with `we_ostatni` = 1 at slot k < LICZBA-1 stores the word in slot k.
  - Slots k+1..LICZBA-1 are filled with all-ones in the same edge, so the padding sorts to the top outputs.
  - The state moves to `PELNY`, `licznik` returns to 0, and `wy_liczba` = k+1.
  - A full block sets `wy_liczba` = 6.
  - `we_ostatni` at slot LICZBA-1 is equivalent to a normal 6th word.
- When undefined: the ports are absent and every block is exactly six words.

## Test plan
- Reset, then back-to-back words 5,3,9,0,F,1 with `wy_przyjete` = 0 → `wy_wazne` = 1 one cycle after the 6th edge; `wy_dane` slots = 5,3,9,0,F,1; `we_gotowy` = 0; network outputs 0,1,3,5,9,F.
- Hold `PELNY` 10 cycles while driving `we_wazne` = 1 with data 7 → `wy_dane` unchanged, `we_gotowy` = 0; pulse `wy_przyjete` → `wy_wazne` = 0 and `we_gotowy` = 1 in the next cycle.
- Words with random `we_wazne` gaps (values 2,2,8,8,4,4) → slots hold 2,2,8,8,4,4; `wy_wazne` rises only after the 6th accepted word.
- Assert `reset_n` = 0 after 3 accepted words, release, then send 6 new words → block contains only the new words; no early `wy_wazne`.
- With `ZBIERACZ_DOPELNIENIE_EN` defined: words 6,2 with `we_ostatni` on the 2nd → slots 6,2,F,F,F,F; `wy_liczba` = 2; `wy_wazne` = 1 next cycle.
- Two consecutive full blocks with acknowledge in the first `PELNY` cycle → second block accepted starting the cycle after the acknowledge; no word lost or duplicated.
